mult_seq_control: RTL and testbench
===================================

MULT_SEQ_CONTROL -- requirements
Module: mult_seq_control

Interface
REQ-001: Parameter N, default 32, is the operand width in bits and the Booth iteration count.
REQ-002: Derived localparam DATA_W = 2*N+1 (65 at default) is the controlled accumulator register width, informative only.
REQ-003: clk  input  1  rising-edge clock, the only clock.
REQ-004: reset  input  1  synchronous, active-high reset.
REQ-005: start  input  1  request a multiply; sampled only in IDLE.
REQ-006: q0  input  1  LSB of the multiplier field of the datapath register.
REQ-007: q_minus1  input  1  Booth guard bit of the datapath register.
REQ-008: load_en  output  1  load operands into the datapath register.
REQ-009: sync_clear  output  1  drives the datapath register's synchronous clear.
REQ-010: acc_en  output  1  write the adder/subtractor result into the accumulator field.
REQ-011: alu_sub  output  1  1 = subtract multiplicand, 0 = add.
REQ-012: shift_en  output  1  arithmetic right shift of the whole DATA_W register.
REQ-013: busy  output  1  high in every state except IDLE.
REQ-014: done  output  1  single-cycle completion pulse; the result is valid in that cycle.

Function
REQ-015: The FSM states SHALL be IDLE, LOAD, EVAL, SHIFT and DONE.
REQ-016: In IDLE with start=1, next state SHALL be LOAD; otherwise it SHALL remain IDLE.
REQ-017: LOAD SHALL last one cycle with load_en=1 and sync_clear=1, clear the iteration counter to 0, then go to EVAL.
REQ-018: In EVAL, Booth decode of {q0,q_minus1} SHALL be combinational: 10 -> acc_en=1, alu_sub=1; 01 -> acc_en=1, alu_sub=0; 00/11 -> acc_en=0, alu_sub=0; next state SHALL be SHIFT.
REQ-019: SHIFT SHALL assert shift_en=1 for one cycle and increment the counter; if the counter equals N-1 before the increment, next state SHALL be DONE, else EVAL.
REQ-020: DONE SHALL assert done=1 for exactly one cycle and always return to IDLE; start in DONE SHALL be ignored.
REQ-021: Latency: if start is sampled in cycle 0, LOAD occupies cycle 1, EVAL/SHIFT occupy cycles 2..2N+1, and done is in cycle 2N+2 (cycle 66 at N=32).
REQ-022: start in any state other than IDLE SHALL be ignored and SHALL NOT be queued.
REQ-023: Outputs other than acc_en/alu_sub SHALL be decoded from state only; load_en, acc_en and shift_en SHALL be mutually exclusive.
REQ-024: Counter width SHALL be $clog2(N) bits with no wrap-around; it is used only in the range 0..N-1.

Reset
REQ-025: reset=1 at a clock edge SHALL force IDLE and counter=0 from the next cycle, regardless of current state, including mid-operation.
REQ-026: While in IDLE after reset, every output SHALL be 0; an interrupted operation SHALL NOT produce done.

Configuration
REQ-027: Macro MULT_SEQ_ABORT_EN SHALL, when defined, add input abort (1 bit).
REQ-028: With MULT_SEQ_ABORT_EN defined, abort=1 in any non-IDLE state SHALL assert sync_clear combinationally in that cycle, force next state IDLE, and suppress done.
REQ-029: With MULT_SEQ_ABORT_EN defined, abort SHALL be ignored in IDLE, and reset SHALL have priority over abort.
REQ-030: Without MULT_SEQ_ABORT_EN, the abort port SHALL NOT exist and the FSM SHALL have no abort path.

Structure
REQ-031: Package mult_seq_pkg SHALL hold the state enum type (IDLE, LOAD, EVAL, SHIFT, DONE) and the Booth decode constants (BOOTH_ADD=2'b01, BOOTH_SUB=2'b10).
REQ-032: The iteration counter SHALL be a sub-module iter_counter, parameterised by N, with clear, increment enable and a terminal flag (count==N-1).

Verification
REQ-033: Hold reset=1 for 2 cycles -> busy=0, done=0, all enables 0.
REQ-034: Pulse start in cycle 0 with {q0,q_minus1}=00 throughout -> load_en and sync_clear in cycle 1, acc_en never asserted, 32 shift_en pulses in cycles 3,5,...,65, single done in cycle 66.
REQ-035: Drive {q0,q_minus1}=10, then 01, then 11 in successive EVAL cycles -> acc_en/alu_sub = 1/1, then 1/0, then 0/0.
REQ-036: Raise start again in cycle 20 and hold it through DONE -> no effect; done only in cycle 66, then LOAD in cycle 68.
REQ-037: Assert reset in cycle 30 -> IDLE from cycle 31, no done; a new start in cycle 40 gives done in cycle 106.
REQ-038: With MULT_SEQ_ABORT_EN defined, abort=1 in cycle 10 -> sync_clear=1 in cycle 10, busy=0 from cycle 11, no done pulse.

Source files
------------

// File: rtl/mult_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_seq_pkg
// Description : Shared types and constants for the sequential Booth multiplier
//               controller: FSM state encoding, Booth decode patterns and the
//               iteration-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_seq_pkg;

  // Controller states, explicitly 3 bits wide
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Booth decode of {q0, q_minus1}
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  // Width of a counter spanning 0..n-1; never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : mult_seq_pkg
`default_nettype wire

// File: rtl/mult_seq_control_iter_counter.sv
`default_nettype none
// ============================================================================
// Module      : iter_counter
// Description : Booth iteration counter. Cleared at operand load, stepped once
//               per shift, flags the last iteration (count == N-1). The count
//               holds at N-1 rather than wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module iter_counter
  import mult_seq_pkg::*;
#(
  parameter int N = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic terminal
);

  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_last;

  assign w_last   = (r_count == C_LAST);
  assign terminal = w_last;

  // Count register: cleared by reset or clear, saturates at the last iteration
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (inc && !w_last) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule : iter_counter
`default_nettype wire

// File: rtl/mult_seq_control.sv
`default_nettype none
// ============================================================================
// Module      : mult_seq_control
// Description : Control FSM for a radix-2 Booth sequential multiplier. Drives
//               the load / clear / accumulate / shift enables of a 2*N+1 bit
//               datapath register (accumulator, multiplier, guard bit) over
//               N evaluate/shift iterations and pulses done when the product
//               is valid.
//               Optional feature macro: MULT_SEQ_ABORT_EN adds an abort input
//               that cancels a running multiply.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_seq_control
  import mult_seq_pkg::*;
#(
  parameter int N = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic q0,
  input  logic q_minus1,
`ifdef MULT_SEQ_ABORT_EN
  input  logic abort,
`endif
  output logic load_en,
  output logic sync_clear,
  output logic acc_en,
  output logic alu_sub,
  output logic shift_en,
  output logic busy,
  output logic done
);

  // The controlled datapath register is 2*N+1 bits wide; this block only
  // sequences it and never touches the data itself.

  state_t r_state;
  state_t w_next;
  logic   w_cnt_clear;
  logic   w_cnt_inc;
  logic   w_cnt_last;

  // Counter is cleared while loading operands and stepped once per shift
  assign w_cnt_clear = (r_state == LOAD);
  assign w_cnt_inc   = (r_state == SHIFT);

  iter_counter #(
    .N (N)
  ) u_iter_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_cnt_clear),
    .inc      (w_cnt_inc),
    .terminal (w_cnt_last)
  );

  // State register; reset wins over every other transition
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and output decode; only the Booth enables look at the inputs
  always_comb begin
    w_next     = r_state;
    load_en    = 1'b0;
    sync_clear = 1'b0;
    acc_en     = 1'b0;
    alu_sub    = 1'b0;
    shift_en   = 1'b0;
    busy       = (r_state != IDLE);
    done       = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next = LOAD;
        end
      end
      LOAD: begin
        load_en    = 1'b1;
        sync_clear = 1'b1;
        w_next     = EVAL;
      end
      EVAL: begin
        unique case ({q0, q_minus1})
          BOOTH_SUB: begin
            acc_en  = 1'b1;
            alu_sub = 1'b1;
          end
          BOOTH_ADD: begin
            acc_en  = 1'b1;
          end
          default: begin
            acc_en  = 1'b0;
          end
        endcase
        w_next = SHIFT;
      end
      SHIFT: begin
        shift_en = 1'b1;
        w_next   = w_cnt_last ? DONE : EVAL;
      end
      DONE: begin
        // start is deliberately not looked at here so it cannot be queued
        done   = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase

`ifdef MULT_SEQ_ABORT_EN
    // Abort cancels a running operation: clear the datapath, drop to IDLE
    // and make sure no completion pulse escapes in the same cycle.
    if (abort && (r_state != IDLE)) begin
      sync_clear = 1'b1;
      done       = 1'b0;
      w_next     = IDLE;
    end
`endif
  end

endmodule : mult_seq_control
`default_nettype wire

// File: tb/tb_mult_seq_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_seq_control
// Description : Self-checking bench for mult_seq_control. A timeline model
//               (cycles elapsed since the accepted start) predicts every
//               output each cycle; directed runs cover latency, ignored
//               start, mid-operation reset, Booth decode and abort, followed
//               by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_seq_control;

  localparam int N     = 32;
  localparam int T_END = 2 * N + 2;   // position of the done cycle

  logic clk = 1'b0;
  logic reset, start, q0, q_minus1;
`ifdef MULT_SEQ_ABORT_EN
  logic abort;
`endif
  logic load_en, sync_clear, acc_en, alu_sub, shift_en, busy, done;

  always #5 clk = ~clk;

  mult_seq_control #(
    .N (N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .q0         (q0),
    .q_minus1   (q_minus1),
`ifdef MULT_SEQ_ABORT_EN
    .abort      (abort),
`endif
    .load_en    (load_en),
    .sync_clear (sync_clear),
    .acc_en     (acc_en),
    .alu_sub    (alu_sub),
    .shift_en   (shift_en),
    .busy       (busy),
    .done       (done)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int t        = 0;      // model: 0 idle, else cycles since start accepted
  bit chk_en   = 1'b0;
  logic [6:0] obs;       // {busy,load,sclr,acc,sub,shift,done} this cycle

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
  endtask

  // One clock cycle: apply inputs, compare all outputs to the model, advance it
  task automatic drive(input bit s, input bit a, input bit b, input bit r, input bit ab);
    logic [6:0] exp;
    bit ev, ab_eff;
    @(negedge clk);
    reset    = r;
    start    = s;
    q0       = a;
    q_minus1 = b;
`ifdef MULT_SEQ_ABORT_EN
    abort    = ab;
    ab_eff   = ab;
`else
    ab_eff   = 1'b0;
`endif
    #1;
    ev     = (t >= 2) && (t <= 2 * N + 1) && (t % 2 == 0);
    exp[6] = (t != 0);
    exp[5] = (t == 1);
    exp[4] = (t == 1) || (ab_eff && t != 0);
    exp[3] = ev && (a != b);
    exp[2] = ev && a && !b;
    exp[1] = (t >= 3) && (t <= 2 * N + 1) && (t % 2 == 1);
    exp[0] = (t == T_END) && !ab_eff;
    obs = {busy, load_en, sync_clear, acc_en, alu_sub, shift_en, done};
    if (chk_en) check("outs", obs, exp);
    if (r)                    t = 0;
    else if (ab_eff && t != 0) t = 0;
    else if (t == 0)          t = s ? 1 : 0;
    else if (t == T_END)      t = 0;
    else                      t = t + 1;
  endtask

  initial begin
    int done_k, n_done, n_shift, n_acc, load_k, first_shift_k;

    reset = 1'b1; start = 1'b0; q0 = 1'b0; q_minus1 = 1'b0;
`ifdef MULT_SEQ_ABORT_EN
    abort = 1'b0;
`endif

    // Reset held two cycles; state before the first edge is unknown
    drive(0, 0, 0, 1, 0);
    chk_en = 1'b1;
    drive(0, 0, 0, 1, 0);
    check("reset_outs", 32'(obs), 32'd0);

    // Full run with {q0,q_minus1}=00, start re-raised from cycle 20 through 67
    done_k = -1; n_done = 0; n_shift = 0; n_acc = 0; load_k = -1; first_shift_k = -1;
    for (int k = 0; k <= 69; k++) begin
      drive((k == 0) || (k >= 20 && k <= 67), 0, 0, 0, 0);
      if (obs[0]) begin n_done++; done_k = k; end
      if (obs[1]) begin n_shift++; if (first_shift_k < 0) first_shift_k = k; end
      if (obs[3]) n_acc++;
      if (obs[5] && k > 1 && load_k < 0) load_k = k;
    end
    check("done_cycle", done_k, 66);
    check("done_count", n_done, 1);
    check("shift_count", n_shift, 32);
    check("first_shift", first_shift_k, 3);
    check("acc_count", n_acc, 0);
    check("reload_cycle", load_k, 68);
    drive(0, 0, 0, 1, 0);

    // Reset mid-operation at cycle 30, new start at cycle 40
    done_k = -1; n_done = 0;
    for (int k = 0; k <= 110; k++) begin
      drive((k == 0) || (k == 40), 1'($urandom), 1'($urandom), k == 30, 0);
      if (k == 31) check("idle_after_rst", 32'(obs[6]), 32'd0);
      if (obs[0]) begin n_done++; done_k = k; end
    end
    check("rst_done_count", n_done, 1);
    check("rst_done_cycle", done_k, 106);

    // Booth decode in successive EVAL cycles: 10, 01, 11
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    check("booth_10", 32'(obs[3:2]), 32'b11);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    check("booth_01", 32'(obs[3:2]), 32'b10);
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    check("booth_11", 32'(obs[3:2]), 32'b00);
    drive(0, 0, 0, 1, 0);

`ifdef MULT_SEQ_ABORT_EN
    // Abort at cycle 10 cancels the multiply with no done pulse
    n_done = 0;
    for (int k = 0; k <= 80; k++) begin
      drive(k == 0, 1'($urandom), 1'($urandom), 0, k == 10);
      if (k == 10) check("abort_sclr", 32'(obs[4]), 32'd1);
      if (k == 11) check("abort_busy", 32'(obs[6]), 32'd0);
      if (obs[0]) n_done++;
    end
    check("abort_no_done", n_done, 0);
    // Abort in IDLE has no effect on a following start
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    check("abort_idle_ignored", 32'(obs[5]), 32'd1);
    drive(0, 0, 0, 1, 1);
`endif

    // Randomized traffic
    for (int k = 0; k < 2500; k++) begin
      drive($urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom),
            $urandom_range(0, 299) == 0, $urandom_range(0, 149) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mult_seq_control
`default_nettype wire
